// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port integer register file.
//   rf_state_e      : init sequencer state (clearing the array / ports live)
//   RF_XLEN_DEF     : default data width
//   RF_NREGS_DEF    : default architectural register count
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_XLEN_DEF  = 32;
  localparam int RF_NREGS_DEF = 32;

endpackage

// File: rtl/regfile_sb.sv
// Busy scoreboard for the register file.
//   clk_i, rst_i   : clock / async active-high reset (clears all busy bits)
//   flush_i        : synchronous clear of the whole vector (highest priority)
//   set_i          : mark set_addr_i busy (already qualified by the caller)
//   clr_i          : per write port, clear clr_addr_i[k] (already qualified)
//   busy_o         : full busy vector
// Priority per bit: flush > set > clear > hold. A set beats a same-cycle
// clear because the issuing instruction is a newer producer of that register.
module regfile_sb #(
  parameter int NREGS = 32,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    set_i,
  input  logic [AW-1:0]           set_addr_i,
  input  logic [NWR-1:0]          clr_i,
  input  logic [NWR-1:0][AW-1:0]  clr_addr_i,
  output logic [NREGS-1:0]        busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++)
      if (clr_i[k]) busy_d[clr_addr_i[k]] = 1'b0;
    if (set_i)   busy_d[set_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file.
//   clk_i, rst_i  : clock / async active-high reset (restarts the clear sequence)
//   clr_req_i     : soft clear request, honoured only when ready
//   ready_o       : array cleared, ports live
//   rd_addr_i     : NRD read addresses     -> rd_data_o (combinational), rd_busy_o
//   wr_en_i/wr_addr_i/wr_data_i : NWR write ports, highest index wins on collision
//   sb_set_i/sb_addr_i : mark a destination register busy at issue
//   busy_vec_o    : full scoreboard vector
// After reset the sequencer walks every entry writing zero, so the array
// itself needs no reset. Out-of-range addresses (NREGS not a power of two)
// read as zero and are ignored on write / scoreboard set.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN_DEF,
  parameter int NREGS    = RF_NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_req_i,
  output logic                      ready_o,
  input  logic [NRD-1:0][AW-1:0]    rd_addr_i,
  output logic [NRD-1:0][XLEN-1:0]  rd_data_o,
  output logic [NRD-1:0]            rd_busy_o,
  input  logic [NWR-1:0]            wr_en_i,
  input  logic [NWR-1:0][AW-1:0]    wr_addr_i,
  input  logic [NWR-1:0][XLEN-1:0]  wr_data_i,
  input  logic                      sb_set_i,
  input  logic [AW-1:0]             sb_addr_i,
  output logic [NREGS-1:0]          busy_vec_o
);

  localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS-1);

  rf_state_e        state_q;
  logic [AW-1:0]    clr_cnt_q;
  logic             ready;
  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NWR-1:0]   wq;        // qualified writes this cycle
  logic             sb_set_q;  // qualified scoreboard set
  logic [NREGS-1:0] busy_vec;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < NREGS_W;
  endfunction

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign ready   = (state_q == RF_READY);
  assign ready_o = ready;

  // ---------------------------------------------------------------- sequencer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      unique case (state_q)
        RF_CLEAR: begin
          if (clr_cnt_q == LAST_IDX) begin
            state_q   <= RF_READY;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        RF_READY: begin
          if (clr_req_i) begin
            state_q   <= RF_CLEAR;
            clr_cnt_q <= '0;
          end
        end
        default: begin
          state_q   <= RF_CLEAR;
          clr_cnt_q <= '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------- write qualification
  for (genvar k = 0; k < NWR; k++) begin : g_wq
    assign wq[k] = ready && wr_en_i[k] && in_range(wr_addr_i[k]) && !is_zero(wr_addr_i[k]);
  end

  assign sb_set_q = ready && sb_set_i && in_range(sb_addr_i) && !is_zero(sb_addr_i);

  // ------------------------------------------------------------------ storage
  // Ascending port loop: the last (highest-index) qualifying write to an
  // address lands, giving the required collision priority.
  always_ff @(posedge clk_i) begin
    if (!ready) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (wq[k]) mem_q[wr_addr_i[k]] <= wr_data_i[k];
    end
  end

  // --------------------------------------------------------------- scoreboard
  regfile_sb #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (ready && clr_req_i),
    .set_i      (sb_set_q),
    .set_addr_i (sb_addr_i),
    .clr_i      (wq),
    .clr_addr_i (wr_addr_i),
    .busy_o     (busy_vec)
  );

  assign busy_vec_o = busy_vec;

  // -------------------------------------------------------------- read ports
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic            hit;
    logic [XLEN-1:0] byp;
    logic            ok;

    // Forwarding: highest-index qualifying write to this address wins.
    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int k = 0; k < NWR; k++) begin
        if ((BYPASS != 0) && wq[k] && (wr_addr_i[k] == rd_addr_i[p])) begin
          hit = 1'b1;
          byp = wr_data_i[k];
        end
      end
    end

    assign ok           = ready && in_range(rd_addr_i[p]) && !is_zero(rd_addr_i[p]);
    assign rd_data_o[p] = !ok ? '0 : (hit ? byp : mem_q[rd_addr_i[p]]);
    // A forwarded result means the producer has completed, so not busy.
    assign rd_busy_o[p] = ok && !hit && busy_vec[rd_addr_i[p]];
  end

endmodule
